// File: rtl/cu_seq_decoder_pkg.sv
// Shared opcode map, ALU selector, control-word layout and FSM states for the decode-stage control unit.
package cu_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LDD  = 4'd1;
   localparam logic [3:0] OP_STD  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_IN   = 4'd5;
   localparam logic [3:0] OP_OUT  = 4'd6;
   localparam logic [3:0] OP_PUSH = 4'd7;
   localparam logic [3:0] OP_POP  = 4'd8;
   localparam logic [3:0] OP_JMP  = 4'd9;
   localparam logic [3:0] OP_CALL = 4'd10;
   localparam logic [3:0] OP_RET  = 4'd11;

   typedef enum logic [1:0] {
      ALU_PASS = 2'd0,
      ALU_ADD  = 2'd1,
      ALU_NOT  = 2'd2
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } state_e;

   typedef struct packed {
      logic    ctrl_valid;
      alu_op_e alu_op;
      logic    alu_src;
      logic    mem_w;
      logic    mem_r;
      logic    mtr;
      logic    reg_write;
      logic    branch;
      logic    in_en;
      logic    out_en;
      logic    stack_op;
      logic    push;
      logic    seq_busy;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_ZERO = '0;

endpackage

// File: rtl/cu_decode_lut.sv
// Combinational opcode lookup: base control word, legality, and whether the op is a sequenced stack op.
module cu_decode_lut
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 5
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output ctrl_word_t          word_o,
   output logic                legal_o,
   output logic                stk_seq_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      word_o            = CTRL_ZERO;
      word_o.ctrl_valid = 1'b1;
      legal_o           = 1'b1;
      stk_seq_o         = 1'b0;
      case (opcode_i)
         OPCODE_W'(OP_NOP): ;
         OPCODE_W'(OP_LDD): begin
            word_o.alu_op    = ALU_PASS;
            word_o.mem_r     = 1'b1;
            word_o.mtr       = 1'b1;
            word_o.reg_write = 1'b1;
         end
         OPCODE_W'(OP_STD): word_o.mem_w = 1'b1;
         OPCODE_W'(OP_ADD): begin
            word_o.alu_op    = ALU_ADD;
            word_o.reg_write = 1'b1;
         end
         OPCODE_W'(OP_NOT): begin
            word_o.alu_op    = ALU_NOT;
            word_o.reg_write = 1'b1;
         end
         OPCODE_W'(OP_IN): begin
            word_o.in_en     = 1'b1;
            word_o.reg_write = 1'b1;
         end
         OPCODE_W'(OP_OUT): word_o.out_en = 1'b1;
         OPCODE_W'(OP_PUSH): begin
            word_o.stack_op = 1'b1;
            word_o.push     = 1'b1;
            word_o.mem_w    = 1'b1;
         end
         OPCODE_W'(OP_POP): begin
            word_o.stack_op  = 1'b1;
            word_o.mem_r     = 1'b1;
            word_o.mtr       = 1'b1;
            word_o.reg_write = 1'b1;
         end
         OPCODE_W'(OP_JMP): word_o.branch = 1'b1;
         // CALL/RET carry their per-beat stack bits; branch/seq_busy are added by the sequencer.
         OPCODE_W'(OP_CALL): begin
            word_o.stack_op = 1'b1;
            word_o.push     = 1'b1;
            word_o.mem_w    = 1'b1;
            stk_seq_o       = 1'b1;
         end
         OPCODE_W'(OP_RET): begin
            word_o.stack_op = 1'b1;
            word_o.mem_r    = 1'b1;
            stk_seq_o       = 1'b1;
         end
         default: begin
            word_o  = CTRL_ZERO;
            legal_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/cu_seq_decoder.sv
// Decode-stage control unit: registered control word, CALL/RET beat sequencer, stall hold and flush bubble.
module cu_seq_decoder
   import cu_pkg::*;
#(
   parameter int OPCODE_W  = 5,
   parameter int ALU_OP_W  = 3,
   parameter int STK_BEATS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                stall,
   input  logic                flush,
   output logic                ctrl_valid,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_src,
   output logic                mem_w,
   output logic                mem_r,
   output logic                mtr,
   output logic                reg_write,
   output logic                branch,
   output logic                in_en,
   output logic                out_en,
   output logic                stack_op,
   output logic                push,
   output logic                seq_busy,
   output logic                illegal
);

   localparam int               CNT_W     = $clog2(STK_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(STK_BEATS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] beat_q, beat_d, beat_inc;
   ctrl_word_t       ctrl_q, ctrl_d, lut_word;
   logic             illegal_q, illegal_d;
   logic             lut_legal, lut_stk_seq;

   cu_decode_lut #(.OPCODE_W(OPCODE_W)) u_lut (
      .opcode_i  (opcode),
      .word_o    (lut_word),
      .legal_o   (lut_legal),
      .stk_seq_o (lut_stk_seq)
   );

   assign beat_inc = beat_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      if (flush) begin
         state_d   = ST_IDLE;
         beat_d    = '0;
         ctrl_d    = CTRL_ZERO;
         illegal_d = 1'b0;
      end else if (!stall) begin
         illegal_d = 1'b0;
         case (state_q)
            // Stack bits latched on beat 0 persist; only beat position flags change.
            ST_SEQ: begin
               beat_d          = beat_inc;
               ctrl_d.branch   = (beat_inc == LAST_BEAT);
               ctrl_d.seq_busy = (beat_inc != LAST_BEAT);
               if (beat_inc == LAST_BEAT) state_d = ST_IDLE;
            end
            default: begin
               beat_d = '0;
               ctrl_d = CTRL_ZERO;
               if (instr_valid) begin
                  if (!lut_legal) begin
                     illegal_d = 1'b1;
                  end else begin
                     ctrl_d = lut_word;
                     if (lut_stk_seq) begin
                        ctrl_d.branch   = (STK_BEATS == 1);
                        ctrl_d.seq_busy = (STK_BEATS > 1);
                        if (STK_BEATS > 1) state_d = ST_SEQ;
                     end
                  end
               end
            end
         endcase
      end
   end

   // NOTE: only control registers live here, so all of them take the async reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         ctrl_q    <= CTRL_ZERO;
         illegal_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
         state_q   <= state_d;
         beat_q    <= beat_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   assign ctrl_valid = ctrl_q.ctrl_valid;
   assign alu_op     = ALU_OP_W'(ctrl_q.alu_op);
   assign alu_src    = ctrl_q.alu_src;
   assign mem_w      = ctrl_q.mem_w;
   assign mem_r      = ctrl_q.mem_r;
   assign mtr        = ctrl_q.mtr;
   assign reg_write  = ctrl_q.reg_write;
   assign branch     = ctrl_q.branch;
   assign in_en      = ctrl_q.in_en;
   assign out_en     = ctrl_q.out_en;
   assign stack_op   = ctrl_q.stack_op;
   assign push       = ctrl_q.push;
   assign seq_busy   = ctrl_q.seq_busy;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_cu_seq_decoder.sv
// Scoreboard bench: three instances (STK_BEATS = 2, 1, 4) share stimulus; expected words are queued per cycle.
module tb_cu_seq_decoder;

   localparam int NDUT              = 3;
   localparam int BEATS [NDUT]      = '{2, 1, 4};

   // Output vector layout: {ctrl_valid, alu_op[2:0], alu_src, mem_w, mem_r, mtr,
   //                        reg_write, branch, in_en, out_en, stack_op, push, seq_busy, illegal}
   localparam logic [15:0] V     = 16'h8000;
   localparam logic [15:0] A_ADD = 16'h1000;
   localparam logic [15:0] A_NOT = 16'h2000;
   localparam logic [15:0] MW    = 16'h0400;
   localparam logic [15:0] MR    = 16'h0200;
   localparam logic [15:0] MTR   = 16'h0100;
   localparam logic [15:0] RW    = 16'h0080;
   localparam logic [15:0] BR    = 16'h0040;
   localparam logic [15:0] IN    = 16'h0020;
   localparam logic [15:0] OUT   = 16'h0010;
   localparam logic [15:0] SO    = 16'h0008;
   localparam logic [15:0] PU    = 16'h0004;
   localparam logic [15:0] SB    = 16'h0002;
   localparam logic [15:0] IL    = 16'h0001;
   localparam logic [15:0] Z     = 16'h0000;
   localparam logic [15:0] C     = V | SO | PU | MW;
   localparam logic [15:0] R     = V | SO | MR;

   localparam logic [4:0]  DEC_OP  [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
   localparam logic [15:0] DEC_EXP [10] = '{V, V | MR | MTR | RW, V | MW, V | A_ADD | RW, V | A_NOT | RW,
                                            V | IN | RW, V | OUT, V | SO | PU | MW, V | SO | MR | MTR | RW,
                                            V | BR};

   typedef struct {
      string                   name;
      logic [NDUT-1:0][15:0]   e;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   instr_valid = 1'b0;
   logic                   stall = 1'b0;
   logic                   flush = 1'b0;
   logic [4:0]             opcode = '0;
   wire  [NDUT-1:0][15:0]  act;
   exp_t                   exp_q [$];
   exp_t                   mon_x;
   int                     n_tests = 0;
   int                     n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      cu_seq_decoder #(.OPCODE_W(5), .ALU_OP_W(3), .STK_BEATS(BEATS[g])) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .instr_valid (instr_valid),
         .opcode      (opcode),
         .stall       (stall),
         .flush       (flush),
         .ctrl_valid  (act[g][15]),
         .alu_op      (act[g][14:12]),
         .alu_src     (act[g][11]),
         .mem_w       (act[g][10]),
         .mem_r       (act[g][9]),
         .mtr         (act[g][8]),
         .reg_write   (act[g][7]),
         .branch      (act[g][6]),
         .in_en       (act[g][5]),
         .out_en      (act[g][4]),
         .stack_op    (act[g][3]),
         .push        (act[g][2]),
         .seq_busy    (act[g][1]),
         .illegal     (act[g][0])
      );
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_all_zero(input string name);
      for (int g = 0; g < NDUT; g++) check($sformatf("%s/beats%0d", name, BEATS[g]), act[g], Z);
   endtask

   // Drive one cycle of inputs and queue the words expected after the next rising edge.
   task automatic step(input string name, input logic v, input logic [4:0] op, input logic s,
                       input logic f, input logic [15:0] e2, input logic [15:0] e1, input logic [15:0] e4);
      exp_t x;
      @(negedge clk);
      instr_valid = v;
      opcode      = op;
      stall       = s;
      flush       = f;
      x.name      = name;
      x.e         = {e4, e1, e2};
      exp_q.push_back(x);
   endtask

   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         mon_x = exp_q.pop_front();
         for (int g = 0; g < NDUT; g++)
            check($sformatf("%s/beats%0d", mon_x.name, BEATS[g]), act[g], mon_x.e[g]);
      end
   end

   initial begin
      #12;
      check_all_zero("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         step($sformatf("dec_op%0d", DEC_OP[i]), 1'b1, DEC_OP[i], 1'b0, 1'b0, DEC_EXP[i], DEC_EXP[i], DEC_EXP[i]);
      step("bubble",        1'b0, 5'd3,  1'b0, 1'b0, Z, Z, Z);

      step("illegal31",     1'b1, 5'd31, 1'b0, 1'b0, IL, IL, IL);
      step("illegal_clr",   1'b0, 5'd0,  1'b0, 1'b0, Z, Z, Z);
      step("illegal12",     1'b1, 5'd12, 1'b0, 1'b0, IL, IL, IL);
      step("nop_after_il",  1'b1, 5'd0,  1'b0, 1'b0, V, V, V);
      step("illegal31b",    1'b1, 5'd31, 1'b0, 1'b0, IL, IL, IL);
      step("flush_il",      1'b0, 5'd0,  1'b0, 1'b1, Z, Z, Z);

      step("call_b0",       1'b1, 5'd10, 1'b0, 1'b0, C | SB, C | BR, C | SB);
      step("call_b1",       1'b1, 5'd3,  1'b0, 1'b0, C | BR, V | A_ADD | RW, C | SB);
      step("call_b2",       1'b0, 5'd0,  1'b0, 1'b0, Z, Z, C | SB);
      step("call_b3",       1'b0, 5'd0,  1'b0, 1'b0, Z, Z, C | BR);
      step("call_done",     1'b0, 5'd0,  1'b0, 1'b0, Z, Z, Z);

      step("scall_b0",      1'b1, 5'd10, 1'b0, 1'b0, C | SB, C | BR, C | SB);
      for (int i = 0; i < 3; i++)
         step($sformatf("scall_hold%0d", i), 1'b1, 5'd3, 1'b1, 1'b0, C | SB, C | BR, C | SB);
      step("scall_b1",      1'b0, 5'd0,  1'b0, 1'b0, C | BR, Z, C | SB);
      step("scall_b2",      1'b0, 5'd0,  1'b0, 1'b0, Z, Z, C | SB);
      step("scall_b3",      1'b0, 5'd0,  1'b0, 1'b0, Z, Z, C | BR);
      step("scall_done",    1'b0, 5'd0,  1'b0, 1'b0, Z, Z, Z);

      step("ret_b0",        1'b1, 5'd11, 1'b0, 1'b0, R | SB, R | BR, R | SB);
      step("ret_flush",     1'b1, 5'd3,  1'b1, 1'b1, Z, Z, Z);
      step("post_flush",    1'b1, 5'd3,  1'b0, 1'b0, V | A_ADD | RW, V | A_ADD | RW, V | A_ADD | RW);
      step("post_flush_bb", 1'b0, 5'd0,  1'b0, 1'b0, Z, Z, Z);

      step("rcall_b0",      1'b1, 5'd10, 1'b0, 1'b0, C | SB, C | BR, C | SB);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      instr_valid = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      rst_n       = 1'b1;
      step("rst_no_beat",   1'b0, 5'd0,  1'b0, 1'b0, Z, Z, Z);
      step("rst_nop",       1'b1, 5'd0,  1'b0, 1'b0, V, V, V);
      step("rst_bubble",    1'b0, 5'd0,  1'b0, 1'b0, Z, Z, Z);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #4;
      check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
